// File: rtl/ysyx_22041461_bru.sv
// Branch resolution unit for the RV64 EX stage.
// Captures a branch/jump, resolves taken/target/link one cycle later, and
// either raises a misaligned-target exception or issues a held redirect to IF
// whose handshake produces a single flush pulse.
module ysyx_22041461_bru #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_kind,
   input  logic [2:0]       in_funct3,
   input  logic [1:0]       in_cmp,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_imm,
   input  logic [XLEN-1:0]  in_rs1,
   output logic             res_valid,
   output logic             res_taken,
   output logic [XLEN-1:0]  res_link,
   output logic             redir_valid,
   input  logic             redir_ready,
   output logic [XLEN-1:0]  redir_pc,
   output logic             flush,
   output logic             exc_valid,
   output logic [XLEN-1:0]  exc_tval,
   output logic [CNT_W-1:0] cnt_resolved,
   output logic [CNT_W-1:0] cnt_taken
);

   typedef enum logic [1:0] {IDLE, RESOLVE, REDIRECT} state_t;

   localparam logic [1:0] KIND_COND = 2'b01;
   localparam logic [1:0] KIND_JAL  = 2'b10;
   localparam logic [1:0] KIND_JALR = 2'b11;

   state_t            state, state_nxt;
   logic [1:0]        kind_q;
   logic [2:0]        funct3_q;
   logic [1:0]        cmp_q;
   logic [XLEN-1:0]   pc_q, imm_q, rs1_q;

   logic              accept;
   logic              cond_taken, taken, aligned, go_redir;
   logic [XLEN-1:0]   sum, target, link;

   assign accept = in_valid && in_ready;

   // Operand capture: everything needed for resolution is latched on accept,
   // so the redirect target stays stable however long IF stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         kind_q   <= '0;
         funct3_q <= '0;
         cmp_q    <= '0;
         pc_q     <= '0;
         imm_q    <= '0;
         rs1_q    <= '0;
      end else if (accept) begin
         kind_q   <= in_kind;
         funct3_q <= in_funct3;
         cmp_q    <= in_cmp;
         pc_q     <= in_pc;
         imm_q    <= in_imm;
         rs1_q    <= in_rs1;
      end
   end

   // Conditional-branch decision from the precomputed compare code;
   // cmp 11 falls out naturally as "not equal, not less".
   always_comb begin
      cond_taken = 1'b0;
      case (funct3_q)
         3'b000:         cond_taken = (cmp_q == 2'b00);
         3'b001:         cond_taken = (cmp_q != 2'b00);
         3'b100, 3'b110: cond_taken = (cmp_q == 2'b01);
         3'b101, 3'b111: cond_taken = (cmp_q != 2'b01);
         default:        cond_taken = 1'b0;
      endcase
   end

   // Taken, target and link; adders wrap modulo 2^XLEN.
   always_comb begin
      taken = 1'b0;
      case (kind_q)
         KIND_COND: taken = cond_taken;
         KIND_JAL,
         KIND_JALR: taken = 1'b1;
         default:   taken = 1'b0;
      endcase
      sum      = (kind_q == KIND_JALR) ? (rs1_q + imm_q) : (pc_q + imm_q);
      target   = {sum[XLEN-1:1], (kind_q == KIND_JALR) ? 1'b0 : sum[0]};
      link     = pc_q + XLEN'(4);
      aligned  = (target[1:0] == 2'b00);
      go_redir = taken && aligned;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state: the redirect handshake is already honoured in RESOLVE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (accept) state_nxt = RESOLVE;
         RESOLVE:  state_nxt = (go_redir && !redir_ready) ? REDIRECT : IDLE;
         REDIRECT: if (redir_ready) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Outputs: data buses are zeroed whenever their strobe is low.
   always_comb begin
      in_ready    = (state == IDLE);
      res_valid   = (state == RESOLVE);
      res_taken   = res_valid && taken;
      res_link    = res_valid ? link : '0;
      redir_valid = (res_valid && go_redir) || (state == REDIRECT);
      redir_pc    = redir_valid ? target : '0;
      flush       = redir_valid && redir_ready;
      exc_valid   = res_valid && taken && !aligned;
      exc_tval    = exc_valid ? target : '0;
   end

   // Statistics counters, wrapping freely.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_resolved <= '0;
         cnt_taken    <= '0;
      end else begin
         if (res_valid) cnt_resolved <= cnt_resolved + CNT_W'(1);
         if (flush)     cnt_taken    <= cnt_taken + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_ysyx_22041461_bru.sv
// Self-checking bench for ysyx_22041461_bru: scoreboard of predicted
// resolutions, one task per scenario.
module tb_ysyx_22041461_bru;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [1:0]  in_kind;
   logic [2:0]  in_funct3;
   logic [1:0]  in_cmp;
   logic [63:0] in_pc, in_imm, in_rs1;
   logic        res_valid, res_taken;
   logic [63:0] res_link;
   logic        redir_valid, redir_ready;
   logic [63:0] redir_pc;
   logic        flush, exc_valid;
   logic [63:0] exc_tval;
   logic [31:0] cnt_resolved, cnt_taken;

   ysyx_22041461_bru #(.XLEN(64), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_kind(in_kind), .in_funct3(in_funct3), .in_cmp(in_cmp),
      .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1),
      .res_valid(res_valid), .res_taken(res_taken), .res_link(res_link),
      .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
      .flush(flush), .exc_valid(exc_valid), .exc_tval(exc_tval),
      .cnt_resolved(cnt_resolved), .cnt_taken(cnt_taken)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          taken;
      bit          exc;
      bit          redir;
      logic [63:0] tgt;
      logic [63:0] link;
   } exp_t;

   exp_t        sbq[$];
   int          pass_cnt = 0;
   int          total_cnt = 0;
   logic [31:0] exp_res = 0;
   logic [31:0] exp_tkn = 0;

   // Reference model of the resolution rules.
   function automatic exp_t predict(input logic [1:0] k, input logic [2:0] f3,
                                    input logic [1:0] c, input logic [63:0] pc,
                                    input logic [63:0] imm, input logic [63:0] rs1);
      exp_t        e;
      bit          tk;
      logic [63:0] t;
      tk = 0;
      if (k == 2'b01) begin
         case (f3)
            3'd0:       tk = (c == 2'd0);
            3'd1:       tk = (c != 2'd0);
            3'd4, 3'd6: tk = (c == 2'd1);
            3'd5, 3'd7: tk = (c != 2'd1);
            default:    tk = 0;
         endcase
      end else if (k != 2'b00) tk = 1;
      t = (k == 2'b11) ? ((rs1 + imm) & ~64'd1) : (pc + imm);
      e.taken = tk;
      e.exc   = tk && (t[1:0] != 2'b00);
      e.redir = tk && !e.exc;
      e.tgt   = t;
      e.link  = pc + 64'd4;
      return e;
   endfunction

   // Push a prediction; redirect with ready already high completes at once.
   task automatic expect_txn(input logic [1:0] k, input logic [2:0] f3, input logic [1:0] c,
                             input logic [63:0] pc, input logic [63:0] imm, input logic [63:0] rs1);
      exp_t e;
      e = predict(k, f3, c, pc, imm, rs1);
      sbq.push_back(e);
      exp_res++;
      if (e.redir && redir_ready) exp_tkn++;
   endtask

   // Entered at posedge+1 with the DUT idle; returns at posedge+1 of N+1.
   task automatic send(input logic [1:0] k, input logic [2:0] f3, input logic [1:0] c,
                       input logic [63:0] pc, input logic [63:0] imm, input logic [63:0] rs1);
      in_valid = 1; in_kind = k; in_funct3 = f3; in_cmp = c;
      in_pc = pc; in_imm = imm; in_rs1 = rs1;
      @(posedge clk); #1;
      in_valid = 0;
   endtask

   task automatic wait_res(output bit ok);
      ok = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (res_valid === 1'b1) begin ok = 1; break; end
      end
   endtask

   task automatic test_reset;
      rst = 1; in_valid = 0; in_kind = 0; in_funct3 = 0; in_cmp = 0;
      in_pc = 0; in_imm = 0; in_rs1 = 0; redir_ready = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset in_ready got %b want 1", in_ready); else pass_cnt++;
      total_cnt++;
      if ({res_valid, res_taken, redir_valid, flush, exc_valid} !== 5'b0)
         $display("FAIL reset strobes got %b want 00000", {res_valid, res_taken, redir_valid, flush, exc_valid});
      else pass_cnt++;
      total_cnt++;
      if ({res_link, redir_pc, exc_tval} !== 192'd0) $display("FAIL reset buses got nonzero want 0"); else pass_cnt++;
      total_cnt++;
      if (cnt_resolved !== 0 || cnt_taken !== 0)
         $display("FAIL reset counters got %0d/%0d want 0/0", cnt_resolved, cnt_taken);
      else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_beq;
      exp_t e; bit ok;
      redir_ready = 1;
      expect_txn(2'b01, 3'b000, 2'b00, 64'h8000_0000, 64'h10, 64'h0);
      send(2'b01, 3'b000, 2'b00, 64'h8000_0000, 64'h10, 64'h0);
      wait_res(ok);
      e = sbq.pop_front();
      total_cnt++; if (!ok) $display("FAIL beq res_valid timeout got 0 want 1"); else pass_cnt++;
      total_cnt++; if (res_taken !== e.taken) $display("FAIL beq taken got %b want %b", res_taken, e.taken); else pass_cnt++;
      total_cnt++; if (redir_pc !== e.tgt) $display("FAIL beq redir_pc got %h want %h", redir_pc, e.tgt); else pass_cnt++;
      total_cnt++; if (res_link !== e.link) $display("FAIL beq link got %h want %h", res_link, e.link); else pass_cnt++;
      total_cnt++; if (flush !== 1'b1 || redir_valid !== 1'b1) $display("FAIL beq flush/redir got %b%b want 11", flush, redir_valid); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (in_ready !== 1'b1 || flush !== 1'b0) $display("FAIL beq n+2 ready/flush got %b%b want 10", in_ready, flush); else pass_cnt++;
      total_cnt++; if (cnt_taken !== exp_tkn) $display("FAIL beq cnt_taken got %0d want %0d", cnt_taken, exp_tkn); else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_bgeu;
      exp_t e; bit ok;
      expect_txn(2'b01, 3'b111, 2'b01, 64'h8000_0100, 64'h40, 64'h0);
      send(2'b01, 3'b111, 2'b01, 64'h8000_0100, 64'h40, 64'h0);
      wait_res(ok);
      e = sbq.pop_front();
      total_cnt++; if (!ok) $display("FAIL bgeu res_valid timeout got 0 want 1"); else pass_cnt++;
      total_cnt++; if (res_taken !== e.taken) $display("FAIL bgeu taken got %b want %b", res_taken, e.taken); else pass_cnt++;
      total_cnt++; if (redir_valid !== 1'b0 || flush !== 1'b0) $display("FAIL bgeu redir/flush got %b%b want 00", redir_valid, flush); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL bgeu n+2 in_ready got %b want 1", in_ready); else pass_cnt++;
      total_cnt++;
      if (cnt_resolved !== exp_res || cnt_taken !== exp_tkn)
         $display("FAIL bgeu counters got %0d/%0d want %0d/%0d", cnt_resolved, cnt_taken, exp_res, exp_tkn);
      else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_jalr_misaligned;
      exp_t e; bit ok;
      redir_ready = 1;
      expect_txn(2'b11, 3'b000, 2'b00, 64'h8000_0200, 64'h0, 64'h8000_1003);
      send(2'b11, 3'b000, 2'b00, 64'h8000_0200, 64'h0, 64'h8000_1003);
      wait_res(ok);
      e = sbq.pop_front();
      total_cnt++; if (!ok) $display("FAIL jalr res_valid timeout got 0 want 1"); else pass_cnt++;
      total_cnt++; if (exc_valid !== e.exc) $display("FAIL jalr exc_valid got %b want %b", exc_valid, e.exc); else pass_cnt++;
      total_cnt++; if (exc_tval !== e.tgt) $display("FAIL jalr exc_tval got %h want %h", exc_tval, e.tgt); else pass_cnt++;
      total_cnt++; if (redir_valid !== 1'b0 || flush !== 1'b0) $display("FAIL jalr redir/flush got %b%b want 00", redir_valid, flush); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (exc_valid !== 1'b0) $display("FAIL jalr exc pulse width got %b want 0", exc_valid); else pass_cnt++;
      total_cnt++; if (cnt_taken !== exp_tkn) $display("FAIL jalr cnt_taken got %0d want %0d", cnt_taken, exp_tkn); else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_jal_stall;
      exp_t e;
      redir_ready = 0;
      expect_txn(2'b10, 3'b000, 2'b00, 64'h1000, 64'h20, 64'h0);
      e = sbq.pop_front();
      send(2'b10, 3'b000, 2'b00, 64'h1000, 64'h20, 64'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i == 0) begin
            total_cnt++;
            if (res_valid !== 1'b1 || res_link !== e.link)
               $display("FAIL stall res got v=%b link=%h want v=1 link=%h", res_valid, res_link, e.link);
            else pass_cnt++;
         end
         total_cnt++;
         if (redir_valid !== 1'b1 || redir_pc !== e.tgt || flush !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL stall hold[%0d] got v=%b pc=%h f=%b rdy=%b want v=1 pc=%h f=0 rdy=0",
                     i, redir_valid, redir_pc, flush, in_ready, e.tgt);
         else pass_cnt++;
         @(posedge clk); #1;
      end
      redir_ready = 1;
      exp_tkn++;
      @(negedge clk);
      total_cnt++;
      if (redir_valid !== 1'b1 || redir_pc !== e.tgt || flush !== 1'b1 || in_ready !== 1'b0)
         $display("FAIL stall handshake got v=%b pc=%h f=%b rdy=%b want v=1 pc=%h f=1 rdy=0",
                  redir_valid, redir_pc, flush, in_ready, e.tgt);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (redir_valid !== 1'b0 || flush !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL stall release got v=%b f=%b rdy=%b want 0 0 1", redir_valid, flush, in_ready);
      else pass_cnt++;
      total_cnt++; if (cnt_taken !== exp_tkn) $display("FAIL stall cnt_taken got %0d want %0d", cnt_taken, exp_tkn); else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_wrap;
      exp_t e; bit ok;
      redir_ready = 1;
      expect_txn(2'b10, 3'b000, 2'b00, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 64'h0);
      send(2'b10, 3'b000, 2'b00, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 64'h0);
      wait_res(ok);
      e = sbq.pop_front();
      total_cnt++; if (!ok) $display("FAIL wrap res_valid timeout got 0 want 1"); else pass_cnt++;
      total_cnt++; if (redir_pc !== e.tgt) $display("FAIL wrap redir_pc got %h want %h", redir_pc, e.tgt); else pass_cnt++;
      total_cnt++; if (res_link !== e.link) $display("FAIL wrap link got %h want %h", res_link, e.link); else pass_cnt++;
      @(posedge clk); #1;
   endtask

   // Sweep every funct3 x cmp code plus the illegal kind, some targets misaligned.
   task automatic test_cond_table;
      exp_t        e; bit ok;
      logic [1:0]  k;
      logic [2:0]  f3;
      logic [1:0]  c;
      logic [63:0] pc, imm;
      redir_ready = 1;
      for (int i = 0; i < 36; i++) begin
         k   = (i < 32) ? 2'b01 : 2'b00;
         f3  = 3'(i >> 2);
         c   = 2'(i);
         pc  = 64'h4000_0000 + 64'(i * 16);
         imm = (i % 5 == 0) ? 64'h6 : 64'(i * 4 + 8);
         expect_txn(k, f3, c, pc, imm, 64'h0);
         send(k, f3, c, pc, imm, 64'h0);
         wait_res(ok);
         e = sbq.pop_front();
         total_cnt++;
         if (!ok || res_taken !== e.taken || redir_valid !== e.redir || flush !== e.redir || exc_valid !== e.exc)
            $display("FAIL table[%0d] k=%b f3=%b cmp=%b got v=%b t=%b r=%b f=%b x=%b want t=%b r=%b x=%b",
                     i, k, f3, c, ok, res_taken, redir_valid, flush, exc_valid, e.taken, e.redir, e.exc);
         else pass_cnt++;
         @(posedge clk); #1;
      end
      @(negedge clk);
      total_cnt++;
      if (cnt_resolved !== exp_res || cnt_taken !== exp_tkn)
         $display("FAIL table counters got %0d/%0d want %0d/%0d", cnt_resolved, cnt_taken, exp_res, exp_tkn);
      else pass_cnt++;
      @(posedge clk); #1;
   endtask

   // Second request held during RESOLVE must be taken only once idle again.
   task automatic test_back_to_back;
      exp_t e;
      redir_ready = 1;
      expect_txn(2'b01, 3'b001, 2'b10, 64'h9000, 64'h100, 64'h0);
      expect_txn(2'b10, 3'b000, 2'b00, 64'hA000, 64'h44, 64'h0);
      in_valid = 1; in_kind = 2'b01; in_funct3 = 3'b001; in_cmp = 2'b10;
      in_pc = 64'h9000; in_imm = 64'h100; in_rs1 = 0;
      @(posedge clk); #1;
      in_kind = 2'b10; in_funct3 = 3'b000; in_cmp = 2'b00; in_pc = 64'hA000; in_imm = 64'h44;
      @(negedge clk);
      e = sbq.pop_front();
      total_cnt++;
      if (res_valid !== 1'b1 || redir_pc !== e.tgt || in_ready !== 1'b0)
         $display("FAIL b2b first got v=%b pc=%h rdy=%b want v=1 pc=%h rdy=0", res_valid, redir_pc, in_ready, e.tgt);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (res_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL b2b gap got v=%b rdy=%b want v=0 rdy=1", res_valid, in_ready);
      else pass_cnt++;
      @(posedge clk); #1;
      in_valid = 0;
      @(negedge clk);
      e = sbq.pop_front();
      total_cnt++;
      if (res_valid !== 1'b1 || redir_pc !== e.tgt || res_link !== e.link || flush !== 1'b1)
         $display("FAIL b2b second got v=%b pc=%h link=%h f=%b want v=1 pc=%h link=%h f=1",
                  res_valid, redir_pc, res_link, flush, e.tgt, e.link);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (cnt_resolved !== exp_res || cnt_taken !== exp_tkn)
         $display("FAIL b2b counters got %0d/%0d want %0d/%0d", cnt_resolved, cnt_taken, exp_res, exp_tkn);
      else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_in_redirect;
      redir_ready = 0;
      send(2'b10, 3'b000, 2'b00, 64'h2000, 64'h4, 64'h0);
      @(posedge clk); #1;
      rst = 1;
      @(negedge clk);
      total_cnt++; if (redir_valid !== 1'b1) $display("FAIL rstredir pending got %b want 1", redir_valid); else pass_cnt++;
      @(posedge clk); #1;
      rst = 0; redir_ready = 1;
      exp_res = 0; exp_tkn = 0;
      sbq.delete();
      @(negedge clk);
      total_cnt++;
      if (redir_valid !== 1'b0 || flush !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL rstredir outputs got v=%b f=%b rdy=%b want 0 0 1", redir_valid, flush, in_ready);
      else pass_cnt++;
      total_cnt++;
      if (cnt_resolved !== exp_res || cnt_taken !== exp_tkn)
         $display("FAIL rstredir counters got %0d/%0d want 0/0", cnt_resolved, cnt_taken);
      else pass_cnt++;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_beq();
      test_bgeu();
      test_jalr_misaligned();
      test_jal_stall();
      test_wrap();
      test_cond_table();
      test_back_to_back();
      test_reset_in_redirect();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
